button_conditioner: RTL and testbench

//   Multi-channel front end for the stopwatch push-buttons: synchronises raw pad inputs, debounces them,

---
 rtl/button_conditioner_pkg.sv | 23 ++
 rtl/button_channel.sv | 122 ++++++++++++
 rtl/button_conditioner.sv | 40 ++++
 tb/tb_button_conditioner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: repeat-FSM state encoding
// and the counter-width helper used by every channel.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   // One width covers the debounce and repeat counters so a channel can be
   // sized from whichever interval is longest.
   function automatic int cnt_width(input int debounce_cycles,
                                    input int repeat_delay,
                                    input int repeat_rate);
      int m;
      m = debounce_cycles;
      if (repeat_delay > m) m = repeat_delay;
      if (repeat_rate > m) m = repeat_rate;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debouncer, edge detector and auto-repeat
// FSM. All outputs are registered.
module button_channel
   import button_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic repeat_en,
   output logic level,
   output logic press,
   output logic released,
   output logic step
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       db_cnt;
   logic [CNT_W-1:0]       rp_cnt;
   rep_state_t             state;
   logic                   synced;
   logic                   db_done;
   logic                   rise;
   logic                   fall;
   logic                   rep_due;

   assign synced  = sync_q[SYNC_STAGES-1];
   assign db_done = (synced != level) && (db_cnt == DB_LAST);
   assign rise    = db_done & synced;
   assign fall    = db_done & ~synced;

   // A release or disable in the same cycle as a terminal count suppresses the repeat.
   always_comb begin
      rep_due = 1'b0;
      if (repeat_en && !fall) begin
         if (state == ST_DELAY && rp_cnt == RD_LAST)
            rep_due = 1'b1;
         else if (state == ST_REPEAT && rp_cnt == RR_LAST)
            rep_due = 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values of its neighbours, matching the hardware it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in ^ ACTIVE_LOW};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
         released <= 1'b0;
      end else begin
         press    <= rise;
         released <= fall;
         if (synced == level) begin
            db_cnt <= '0;
         end else if (db_done) begin
            level  <= synced;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // The FSM leaves IDLE on the same edge that raises press, so the first
   // repeat lands exactly REPEAT_DELAY cycles after the press cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         rp_cnt <= '0;
         step   <= 1'b0;
      end else begin
         step <= rise | rep_due;
         if (fall || !repeat_en) begin
            state  <= ST_IDLE;
            rp_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  rp_cnt <= '0;
                  if (rise) state <= ST_DELAY;
               end
               ST_DELAY: begin
                  if (rp_cnt == RD_LAST) begin
                     state  <= ST_REPEAT;
                     rp_cnt <= '0;
                  end else begin
                     rp_cnt <= rp_cnt + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (rp_cnt == RR_LAST) rp_cnt <= '0;
                  else                   rp_cnt <= rp_cnt + 1'b1;
               end
               default: begin
                  state  <= ST_IDLE;
                  rp_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: one independent button_channel per
// pad. The release pulse output is named "released" (release is a keyword).
module button_conditioner #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   input  logic [CHANNELS-1:0] repeat_en,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] released,
   output logic [CHANNELS-1:0] step
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      button_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .btn_in   (btn_in[i]),
         .repeat_en(repeat_en[i]),
         .level    (level[i]),
         .press    (press[i]),
         .released (released[i]),
         .step     (step[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat intervals.
// Outputs are sampled 1 time unit after the rising edge.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] repeat_en;
   logic [3:0] level;
   logic [3:0] press;
   logic [3:0] released;
   logic [3:0] step;
   logic [3:0] step_q;

   int n_cmp = 0;
   int n_bad = 0;

   button_conditioner #(
      .CHANNELS       (4),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_RATE    (3),
      .ACTIVE_LOW     (1'b0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .repeat_en(repeat_en),
      .level    (level),
      .press    (press),
      .released (released),
      .step     (step)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] l, input logic [3:0] p,
                            input logic [3:0] r, input logic [3:0] s);
      check({tag, ".level"}, 32'(level), 32'(l));
      check({tag, ".press"}, 32'(press), 32'(p));
      check({tag, ".release"}, 32'(released), 32'(r));
      check({tag, ".step"}, 32'(step), 32'(s));
   endtask

   // Continuous checks: press/release exclusive and step never two cycles wide.
   always @(negedge clk) begin
      if (rst) begin
         step_q <= 4'b0;
      end else begin
         check("press_and_release", 32'(press & released), 32'd0);
         check("step_width", 32'(step & step_q), 32'd0);
         step_q <= step;
      end
   end

   initial begin
      int steps3;
      logic [3:0] exp_s;
      logic [3:0] exp_r;

      // 1: reset with pads toggling, then release with pads idle
      rst       = 1'b1;
      btn_in    = 4'b0;
      repeat_en = 4'b0;
      cyc(1);
      check_all("reset", 4'b0, 4'b0, 4'b0, 4'b0);
      for (int i = 0; i < 6; i++) begin
         btn_in = ~btn_in;
         cyc(1);
         check_all("reset_toggle", 4'b0, 4'b0, 4'b0, 4'b0);
      end
      btn_in = 4'b0;
      rst    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check_all("post_reset", 4'b0, 4'b0, 4'b0, 4'b0);
      end

      // 2: clean press on ch0, level after the sixth edge
      btn_in[0] = 1'b1;
      cyc(5);
      check("press0_early.level", 32'(level), 32'd0);
      cyc(1);
      check_all("press0", 4'b0001, 4'b0001, 4'b0, 4'b0001);
      cyc(1);
      check_all("press0_after", 4'b0001, 4'b0, 4'b0, 4'b0);

      // 3: bounce on ch1 (3 high, 1 low, 3 high, low) never registers
      btn_in[1] = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         cyc(1);
         check_all("bounce1", 4'b0001, 4'b0, 4'b0, 4'b0);
         if (k == 3) btn_in[1] = 1'b0;
         if (k == 4) btn_in[1] = 1'b1;
         if (k == 7) btn_in[1] = 1'b0;
      end

      // 4: hold ch2 with repeat: steps at P, P+10, P+13 ...; release at P+20
      repeat_en[2] = 1'b1;
      btn_in[2]    = 1'b1;
      cyc(6);
      check_all("press2", 4'b0101, 4'b0100, 4'b0, 4'b0100);
      for (int k = 1; k <= 32; k++) begin
         cyc(1);
         exp_s = (k == 10 || k == 13 || k == 16 || k == 19 || k == 22 || k == 25) ? 4'b0100 : 4'b0;
         exp_r = (k == 26) ? 4'b0100 : 4'b0;
         check("repeat2.step", 32'(step), 32'(exp_s));
         check("repeat2.release", 32'(released), 32'(exp_r));
         if (k == 20) btn_in[2] = 1'b0;
      end
      check("repeat2.level", 32'(level), 32'b0001);
      repeat_en[2] = 1'b0;

      // 5a: ch3 release lands on the edge a repeat is due (P+13)
      repeat_en[3] = 1'b1;
      btn_in[3]    = 1'b1;
      cyc(6);
      check_all("press3", 4'b1001, 4'b1000, 4'b0, 4'b1000);
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         exp_s = (k == 10) ? 4'b1000 : 4'b0;
         exp_r = (k == 13) ? 4'b1000 : 4'b0;
         check("conflict3.step", 32'(step), 32'(exp_s));
         check("conflict3.release", 32'(released), 32'(exp_r));
         if (k == 7) btn_in[3] = 1'b0;
      end

      // 5b: ch3 held 40 cycles with repeat disabled -> single step
      repeat_en[3] = 1'b0;
      btn_in[3]    = 1'b1;
      steps3       = 0;
      for (int k = 1; k <= 46; k++) begin
         cyc(1);
         if (step[3]) steps3++;
         if (k == 40) btn_in[3] = 1'b0;
      end
      check("norepeat3.steps", 32'(steps3), 32'd1);
      cyc(4);
      check("norepeat3.level", 32'(level), 32'b0001);

      // 6: reset mid-hold on ch0 and ch2, then fresh simultaneous presses
      btn_in[2] = 1'b1;
      cyc(8);
      check("hold02.level", 32'(level), 32'b0101);
      rst = 1'b1;
      #1;
      check_all("reset_async", 4'b0, 4'b0, 4'b0, 4'b0);
      cyc(3);
      check_all("reset_held", 4'b0, 4'b0, 4'b0, 4'b0);
      rst = 1'b0;
      cyc(5);
      check_all("rearm_early", 4'b0, 4'b0, 4'b0, 4'b0);
      cyc(1);
      check_all("rearm", 4'b0101, 4'b0101, 4'b0, 4'b0101);
      cyc(1);
      check_all("rearm_after", 4'b0101, 4'b0, 4'b0, 4'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
